// File: rtl/rvc_asap_5pl_fetch.sv
// Q100H/Q101H fetch front end: PC generation, one-entry stall skid
// for the synchronous I_MEM read data, and redirect slot killing.
module rvc_asap_5pl_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        Clock,
    input  logic        Rst,
    input  logic        StallQ101H,
    input  logic        RedirectQ102H,
    input  logic [31:0] RedirectTargetQ102H,
    output logic [31:0] Pc,
    input  logic [31:0] InstructionQ101H,
    output logic [31:0] InstOutQ101H,
    output logic [31:0] PcQ101H,
    output logic [31:0] PcPlus4Q101H,
    output logic        ValidQ101H,
    output logic        FetchFault
);

    logic [31:0] r_pc;
    logic [31:0] r_pc_q101;
    logic [31:0] r_hold_instr;
    logic        r_valid;
    logic        r_hold_valid;
    logic        r_fault;

    logic [31:0] w_pc_next;
    logic        w_advance;
    logic        w_misaligned;

    assign w_advance    = RedirectQ102H | ~StallQ101H;
    assign w_misaligned = RedirectQ102H & (RedirectTargetQ102H[1:0] != 2'b00);

    always_comb begin
        w_pc_next = r_pc + PC_STEP;
        if (RedirectQ102H) begin
            w_pc_next = {RedirectTargetQ102H[31:2], 2'b00};
        end else if (StallQ101H) begin
            w_pc_next = r_pc;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Rst) begin
            r_pc         <= RESET_PC;
            r_pc_q101    <= RESET_PC;
            r_valid      <= 1'b0;
            r_hold_valid <= 1'b0;
            r_hold_instr <= 32'h0;
            r_fault      <= 1'b0;
        end else begin
            r_pc <= w_pc_next;
            if (w_advance) begin
                r_pc_q101    <= r_pc;
                r_valid      <= ~RedirectQ102H;
                r_hold_valid <= 1'b0;
            end else if (!r_hold_valid) begin
                // I_MEM re-reads the held Pc next cycle, so keep this data
                r_hold_valid <= 1'b1;
                r_hold_instr <= InstructionQ101H;
            end
            if (w_misaligned) begin
                r_fault <= 1'b1;
            end
        end
    end

    assign Pc           = r_pc;
    assign PcQ101H      = r_pc_q101;
    assign PcPlus4Q101H = r_pc_q101 + PC_STEP;
    assign ValidQ101H   = r_valid & ~RedirectQ102H;
    assign InstOutQ101H = r_hold_valid ? r_hold_instr : InstructionQ101H;
    assign FetchFault   = r_fault;

endmodule

// File: tb/tb_rvc_asap_5pl_fetch.sv
// Self-checking bench for rvc_asap_5pl_fetch: directed scenarios
// followed by randomized stall/redirect/reset traffic.
module tb_rvc_asap_5pl_fetch;

    logic        Clock;
    logic        Rst;
    logic        Stall;
    logic        Redir;
    logic [31:0] Tgt;
    logic [31:0] Pc;
    logic [31:0] InstrIn;
    logic [31:0] InstOut;
    logic [31:0] PcQ;
    logic [31:0] PcP4;
    logic        Valid;
    logic        Fault;

    int n_vec;
    int n_err;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_qpc;
    logic        m_valid;
    logic        m_fault;

    rvc_asap_5pl_fetch dut (
        .Clock               (Clock),
        .Rst                 (Rst),
        .StallQ101H          (Stall),
        .RedirectQ102H       (Redir),
        .RedirectTargetQ102H (Tgt),
        .Pc                  (Pc),
        .InstructionQ101H    (InstrIn),
        .InstOutQ101H        (InstOut),
        .PcQ101H             (PcQ),
        .PcPlus4Q101H        (PcP4),
        .ValidQ101H          (Valid),
        .FetchFault          (Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // odd multiplier keeps every address mapped to a distinct word
    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    always @(posedge Clock) InstrIn <= mem(Pc);

    task automatic drive(input logic r, input logic s, input logic d,
                         input logic [31:0] t);
        Rst   = r;
        Stall = s;
        Redir = d;
        Tgt   = t;
        @(negedge Clock);
    endtask

    task automatic adv();
        @(posedge Clock);
        if (!Rst) begin
            m_pc    = 32'h0;
            m_qpc   = 32'h0;
            m_valid = 1'b0;
            m_fault = 1'b0;
        end else if (Redir) begin
            m_qpc   = m_pc;
            m_pc    = Tgt & 32'hFFFF_FFFC;
            m_valid = 1'b0;
            if (Tgt % 4 != 0) m_fault = 1'b1;
        end else if (!Stall) begin
            m_qpc   = m_pc;
            m_pc    = m_pc + 32'd4;
            m_valid = 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 32'h0);
        adv();
    endtask

    task automatic test_reset();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h0) begin
            n_err++; $display("FAIL reset_pc: got %h want %h", Pc, 32'h0);
        end
        n_vec++;
        if (PcQ !== 32'h0) begin
            n_err++; $display("FAIL reset_pcq: got %h want %h", PcQ, 32'h0);
        end
        n_vec++;
        if (Valid !== 1'b0) begin
            n_err++; $display("FAIL reset_valid: got %b want 0", Valid);
        end
        n_vec++;
        if (Fault !== 1'b0) begin
            n_err++; $display("FAIL reset_fault: got %b want 0", Fault);
        end
        adv();
    endtask

    task automatic test_freerun();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            n_vec++;
            if (Pc !== 32'(4 * i)) begin
                n_err++; $display("FAIL run_pc: got %h want %h", Pc, 32'(4 * i));
            end
            n_vec++;
            if (PcQ !== 32'(4 * (i - 1)) || Valid !== 1'b1) begin
                n_err++;
                $display("FAIL run_q101: got pc %h v %b want pc %h v 1",
                         PcQ, Valid, 32'(4 * (i - 1)));
            end
            n_vec++;
            if (InstOut !== mem(32'(4 * (i - 1)))) begin
                n_err++;
                $display("FAIL run_inst: got %h want %h",
                         InstOut, mem(32'(4 * (i - 1))));
            end
            n_vec++;
            if (PcP4 !== 32'(4 * i)) begin
                n_err++; $display("FAIL run_pc4: got %h want %h", PcP4, 32'(4 * i));
            end
            adv();
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, 32'h0);
            adv();
        end
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k < 3, 1'b0, 32'h0);
            n_vec++;
            if (PcQ !== 32'h8 || Pc !== 32'hC || Valid !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold: got pc %h q %h v %b want c 8 1",
                         Pc, PcQ, Valid);
            end
            n_vec++;
            if (InstOut !== mem(32'h8)) begin
                n_err++;
                $display("FAIL stall_inst: got %h want %h", InstOut, mem(32'h8));
            end
            adv();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (PcQ !== 32'hC || InstOut !== mem(32'hC) || Pc !== 32'h10) begin
            n_err++;
            $display("FAIL stall_release: got q %h i %h pc %h want c %h 10",
                     PcQ, InstOut, Pc, mem(32'hC));
        end
        adv();
    endtask

    task automatic test_redirect();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        adv();
        drive(1'b1, 1'b0, 1'b1, 32'h100);
        n_vec++;
        if (Valid !== 1'b0 || PcQ !== 32'h14) begin
            n_err++;
            $display("FAIL redir_kill: got v %b q %h want 0 14", Valid, PcQ);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h100 || Valid !== 1'b0) begin
            n_err++;
            $display("FAIL redir_next: got pc %h v %b want 100 0", Pc, Valid);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h104 || PcQ !== 32'h100 || Valid !== 1'b1 ||
            InstOut !== mem(32'h100)) begin
            n_err++;
            $display("FAIL redir_target: got pc %h q %h v %b i %h want 104 100 1 %h",
                     Pc, PcQ, Valid, InstOut, mem(32'h100));
        end
        adv();
    endtask

    task automatic test_redirect_stall();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        adv();
        drive(1'b1, 1'b1, 1'b1, 32'h40);
        n_vec++;
        if (Valid !== 1'b0) begin
            n_err++; $display("FAIL rs_kill: got v %b want 0", Valid);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h40 || Valid !== 1'b0) begin
            n_err++;
            $display("FAIL rs_pc: got pc %h v %b want 40 0", Pc, Valid);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (PcQ !== 32'h40 || Valid !== 1'b1 || InstOut !== mem(32'h40)) begin
            n_err++;
            $display("FAIL rs_target: got q %h v %b i %h want 40 1 %h",
                     PcQ, Valid, InstOut, mem(32'h40));
        end
        adv();
    endtask

    task automatic test_misaligned();
        drive(1'b1, 1'b0, 1'b1, 32'h203);
        n_vec++;
        if (Fault !== 1'b0) begin
            n_err++; $display("FAIL mis_before: got %b want 0", Fault);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h200 || Fault !== 1'b1) begin
            n_err++;
            $display("FAIL mis_set: got pc %h f %b want 200 1", Pc, Fault);
        end
        adv();
        drive(1'b1, 1'b0, 1'b1, 32'h300);
        adv();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, i == 1, 1'b0, 32'h0);
            n_vec++;
            if (Fault !== 1'b1) begin
                n_err++; $display("FAIL mis_sticky: got %b want 1", Fault);
            end
            adv();
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1, 1'b0, 32'h0);
        adv();
        drive(1'b0, 1'b1, 1'b1, 32'h80);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h0 || PcQ !== 32'h0 || Valid !== 1'b0 || Fault !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_state: got pc %h q %h v %b f %b want 0 0 0 0",
                     Pc, PcQ, Valid, Fault);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h4 || Valid !== 1'b1 || InstOut !== mem(32'h0)) begin
            n_err++;
            $display("FAIL rmid_resume: got pc %h v %b i %h want 4 1 %h",
                     Pc, Valid, InstOut, mem(32'h0));
        end
        adv();
    endtask

    task automatic test_wrap();
        drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'hFFFF_FFFC) begin
            n_err++; $display("FAIL wrap_top: got %h want fffffffc", Pc);
        end
        adv();
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        n_vec++;
        if (Pc !== 32'h0 || PcQ !== 32'hFFFF_FFFC || PcP4 !== 32'h0 ||
            Valid !== 1'b1 || InstOut !== mem(32'hFFFF_FFFC)) begin
            n_err++;
            $display("FAIL wrap_zero: got pc %h q %h p4 %h v %b i %h",
                     Pc, PcQ, PcP4, Valid, InstOut);
        end
        adv();
    endtask

    task automatic test_random();
        logic        r;
        logic        s;
        logic        d;
        logic [31:0] t;
        for (int i = 0; i < 400; i++) begin
            r = ($urandom % 50) != 0;
            s = ($urandom % 10) < 3;
            d = ($urandom % 10) == 0;
            t = $urandom & 32'h0000_0FFC;
            if ($urandom % 8 == 0) t = t | ($urandom % 4);
            drive(r, s, d, t);
            n_vec++;
            if (Pc !== m_pc || PcQ !== m_qpc || PcP4 !== m_qpc + 32'd4) begin
                n_err++;
                $display("FAIL rnd_pc: got pc %h q %h p4 %h want %h %h %h",
                         Pc, PcQ, PcP4, m_pc, m_qpc, m_qpc + 32'd4);
            end
            n_vec++;
            if (Valid !== (m_valid & ~d) || Fault !== m_fault) begin
                n_err++;
                $display("FAIL rnd_flags: got v %b f %b want %b %b",
                         Valid, Fault, m_valid & ~d, m_fault);
            end
            if (m_valid && !d) begin
                n_vec++;
                if (InstOut !== mem(m_qpc)) begin
                    n_err++;
                    $display("FAIL rnd_inst: got %h want %h", InstOut, mem(m_qpc));
                end
            end
            adv();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        Rst   = 1'b0;
        Stall = 1'b0;
        Redir = 1'b0;
        Tgt   = 32'h0;
        test_reset();
        test_freerun();
        test_stall();
        test_redirect();
        test_redirect_stall();
        test_misaligned();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
